mealey_stimulus_gen: RTL

- Upstream stimulus stage for the Mealey top entity.
- Produces a deterministic 9-bit signed sample stream that drives the Mealey `eta_i1` input, replacing the don't-care drive currently applied there.
- Four selectable patterns: saturating ramp, wrapping ramp, alternating ±amplitude, LFSR.
- Signals end-of-sequence so a bench can raise its finished flag from `done`.

---
 rtl/mealey_stimulus_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mealey_stimulus_gen.sv
// Stimulus generator feeding the Mealey eta_i1 input: one run of LENGTH signed
// samples drawn from a saturating ramp, wrapping ramp, alternating +/-AMP or a
// 9-bit LFSR, bracketed by busy and a sticky done flag.
// LFSR_SEED must be nonzero; a zero seed locks the LFSR at zero.
module mealey_stimulus_gen #(
  parameter int unsigned        WIDTH     = 9,
  parameter int                 START     = -4,
  parameter int                 STEP      = 3,
  parameter int unsigned        AMP       = 100,
  parameter logic [WIDTH-1:0]   LFSR_SEED = 9'h001,
  parameter int unsigned        LENGTH    = 16
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    hold,
  output logic signed [WIDTH-1:0] eta_o,
  output logic                    eta_valid,
  output logic [7:0]              idx,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [WIDTH-1:0] StartS  = WIDTH'(START);
  localparam logic signed [WIDTH-1:0] StepS   = WIDTH'(STEP);
  localparam logic signed [WIDTH-1:0] AmpS    = WIDTH'(AMP);
  localparam logic [7:0]              LastIdx = 8'(LENGTH - 1);
  localparam logic signed [WIDTH-1:0] MaxS    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MinS    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                    state_q, state_d;
  logic signed [WIDTH-1:0]   eta_q, eta_d;
  logic [7:0]                idx_q, idx_d;
  logic [WIDTH-1:0]          lfsr_q, lfsr_d;
  logic [1:0]                mode_q, mode_d;

  logic signed [WIDTH:0]     sat_sum;
  logic signed [WIDTH-1:0]   next_sample;
  logic signed [WIDTH-1:0]   first_sample;
  logic [WIDTH-1:0]          lfsr_next;
  logic                      accept;

  // State register with synchronous reset.
  always_ff @(posedge system1000) begin
    if (system1000_rst) state_q <= StIdle;
    else                state_q <= state_d;
  end

  // Datapath registers; the LFSR returns to its seed on reset.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      eta_q  <= '0;
      idx_q  <= '0;
      lfsr_q <= LFSR_SEED;
      mode_q <= '0;
    end else begin
      eta_q  <= eta_d;
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
      mode_q <= mode_d;
    end
  end

  // Next state: start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (!hold && idx_q == LastIdx) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Sample arithmetic for every mode.
  always_comb begin
    // Widen by one bit so overflow shows as the top two bits disagreeing.
    sat_sum   = {eta_q[WIDTH-1], eta_q} + {StepS[WIDTH-1], StepS};
    lfsr_next = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-5]};
    unique case (mode_q)
      2'd0: begin
        if (sat_sum[WIDTH] != sat_sum[WIDTH-1]) next_sample = sat_sum[WIDTH] ? MinS : MaxS;
        else                                    next_sample = sat_sum[WIDTH-1:0];
      end
      2'd1:    next_sample = eta_q + StepS;
      2'd2:    next_sample = -eta_q;
      default: next_sample = $signed(lfsr_next);
    endcase
    unique case (mode)
      2'd0, 2'd1: first_sample = StartS;
      2'd2:       first_sample = AmpS;
      default:    first_sample = $signed(LFSR_SEED);
    endcase
  end

  // Datapath next values: load on accepted start, advance or finish in RUN.
  always_comb begin
    eta_d  = eta_q;
    idx_d  = idx_q;
    lfsr_d = lfsr_q;
    mode_d = mode_q;
    accept = (state_q != StRun) && start;
    if (accept) begin
      eta_d  = first_sample;
      idx_d  = '0;
      lfsr_d = LFSR_SEED;
      mode_d = mode;
    end else if (state_q == StRun && !hold) begin
      if (idx_q == LastIdx) begin
        eta_d = '0;
        idx_d = '0;
      end else begin
        eta_d = next_sample;
        idx_d = idx_q + 8'd1;
        if (mode_q == 2'd3) lfsr_d = lfsr_next;
      end
    end
  end

  // Outputs decoded from state; eta_q is zero whenever no run is active.
  always_comb begin
    busy      = (state_q == StRun);
    eta_valid = (state_q == StRun);
    done      = (state_q == StDone);
    eta_o     = eta_q;
    idx       = idx_q;
  end

endmodule
